hwpe_stream_merge_stride_ctrl: RTL and testbench

//  Sequencer for the strided stream merge. Accepts NB_IN_STREAMS independent lane streams, each into
//  its own 1-entry holding register, so lanes need not be valid together. Emits one interleaved,

---
 rtl/hwpe_stream_merge_stride_ctrl.sv | 156 +++++++++++++++
 tb/tb_hwpe_stream_merge_stride_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_merge_stride_ctrl.sv
// Strided stream merge sequencer: buffers one beat per input lane and emits an element-interleaved
// beat whenever every lane holds data, for a transfer of len_i output beats per start_i.
module hwpe_stream_merge_stride_ctrl #(
    parameter int unsigned NB_IN_STREAMS  = 4,
    parameter int unsigned ELEMENT_WIDTH  = 16,
    parameter int unsigned ELEMENT_STRIDE = 4,
    parameter int unsigned DATA_WIDTH_IN  = 64,
    parameter int unsigned LEN_WIDTH      = 16
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       clear_i,
    input  logic                                       start_i,
    input  logic [LEN_WIDTH-1:0]                       len_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic [LEN_WIDTH-1:0]                       beat_cnt_o,
    output logic [1:0]                                 state_dbg_o,
    input  logic [NB_IN_STREAMS-1:0]                   push_valid_i,
    input  logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]     push_data_i,
    input  logic [NB_IN_STREAMS*DATA_WIDTH_IN/8-1:0]   push_strb_i,
    output logic [NB_IN_STREAMS-1:0]                   push_ready_o,
    output logic                                       pop_valid_o,
    output logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]     pop_data_o,
    output logic [NB_IN_STREAMS*DATA_WIDTH_IN/8-1:0]   pop_strb_o,
    input  logic                                       pop_ready_i
);

    localparam int unsigned NB = NB_IN_STREAMS;
    localparam int unsigned DW = DATA_WIDTH_IN;
    localparam int unsigned SW = DATA_WIDTH_IN / 8;
    localparam int unsigned EW = ELEMENT_WIDTH;
    localparam int unsigned EB = ELEMENT_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [LEN_WIDTH-1:0]           len_q, len_d;
    logic [LEN_WIDTH-1:0]           beat_cnt_q, beat_cnt_d;
    logic                           zero_done_q, zero_done_d;
    logic [NB-1:0]                  full_q, full_d;
    logic [NB-1:0][LEN_WIDTH-1:0]   lane_cnt_q, lane_cnt_d;
    logic [NB-1:0][DW-1:0]          data_q;
    logic [NB-1:0][SW-1:0]          strb_q;

    logic                           run;
    logic                           start_accept;
    logic                           pop_fire;
    logic [NB-1:0]                  push_fire;

    // Valid/ready: a beat transfers on a cycle where valid and ready are both high at the
    // rising clock edge; valid never waits on ready, and ready never looks at valid.
    assign run          = (state_q == ST_RUN);
    assign start_accept = (state_q == ST_IDLE) && start_i && (len_i != '0);
    assign pop_valid_o  = run && (&full_q);
    assign pop_fire     = pop_valid_o && pop_ready_i;
    assign busy_o       = run;
    assign done_o       = (state_q == ST_DONE) || zero_done_q;
    assign beat_cnt_o   = beat_cnt_q;
    assign state_dbg_o  = state_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        zero_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        state_d    = ST_RUN;
                        len_d      = len_i;
                        beat_cnt_d = '0;
                    end else begin
                        // Empty transfer: report completion without ever going busy.
                        zero_done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (pop_fire) begin
                    beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                    if (beat_cnt_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A full lane can take a new beat in the same cycle its current beat leaves.
    always_comb begin
        for (int ii = 0; ii < NB; ii++) begin
            push_ready_o[ii] = run && (lane_cnt_q[ii] < len_q) && (!full_q[ii] || pop_fire);
            push_fire[ii]    = push_ready_o[ii] && push_valid_i[ii];
            full_d[ii]       = full_q[ii];
            lane_cnt_d[ii]   = lane_cnt_q[ii];
            if (start_accept) begin
                lane_cnt_d[ii] = '0;
            end
            if (push_fire[ii]) begin
                full_d[ii]     = 1'b1;
                lane_cnt_d[ii] = lane_cnt_q[ii] + LEN_WIDTH'(1);
            end else if (pop_fire) begin
                full_d[ii] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            zero_done_q <= 1'b0;
            full_q      <= '0;
            lane_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            zero_done_q <= zero_done_d;
            full_q      <= full_d;
            lane_cnt_q  <= lane_cnt_d;
        end
    end

    // Payload registers need no reset: they are only observed behind full_q.
    always_ff @(posedge clk_i) begin
        for (int ii = 0; ii < NB; ii++) begin
            if (push_fire[ii]) begin
                data_q[ii] <= push_data_i[ii*DW +: DW];
                strb_q[ii] <= push_strb_i[ii*SW +: SW];
            end
        end
    end

    // Output element k = jj*NB + ii carries element jj of lane ii.
    always_comb begin
        pop_data_o = '0;
        pop_strb_o = '0;
        for (int jj = 0; jj < ELEMENT_STRIDE; jj++) begin
            for (int ii = 0; ii < NB; ii++) begin
                pop_data_o[(jj*NB+ii)*EW +: EW] = data_q[ii][jj*EW +: EW];
                pop_strb_o[(jj*NB+ii)*EB +: EB] = strb_q[ii][jj*EB +: EB];
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_merge_stride_ctrl.sv
// Directed bench for the strided merge sequencer: a transaction-level model predicts every output
// beat from the lane beats it has seen accepted, plus literal checks on hand-computed values.
module tb_hwpe_stream_merge_stride_ctrl;

    localparam int N   = 4;
    localparam int EW  = 16;
    localparam int STR = 4;
    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int LW  = 16;
    localparam int PW  = N * DW;
    localparam int PSW = N * SW;
    localparam int CW  = PW + PSW;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              clear_i = 1'b0;
    logic              start_i = 1'b0;
    logic [LW-1:0]     len_i = '0;
    logic              busy_o, done_o;
    logic [LW-1:0]     beat_cnt_o;
    logic [1:0]        state_dbg_o;
    logic [N-1:0]      push_valid_i = '0;
    logic [PW-1:0]     push_data_i = '0;
    logic [PSW-1:0]    push_strb_i = '0;
    logic [N-1:0]      push_ready_o;
    logic              pop_valid_o;
    logic [PW-1:0]     pop_data_o;
    logic [PSW-1:0]    pop_strb_o;
    logic              pop_ready_i = 1'b1;

    hwpe_stream_merge_stride_ctrl #(
        .NB_IN_STREAMS(N), .ELEMENT_WIDTH(EW), .ELEMENT_STRIDE(STR),
        .DATA_WIDTH_IN(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .beat_cnt_o(beat_cnt_o), .state_dbg_o(state_dbg_o),
        .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_strb_i(push_strb_i),
        .push_ready_o(push_ready_o), .pop_valid_o(pop_valid_o), .pop_data_o(pop_data_o),
        .pop_strb_o(pop_strb_o), .pop_ready_i(pop_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- model and scoreboard ----------------
    logic [CW-1:0]  exp_q[$];
    logic [DW-1:0]  hist_d[N][16];
    logic [SW-1:0]  hist_s[N][16];
    int             m_acc[N];
    int             m_len = 0, m_beats = 0, exp_made = 0, n_fires = 0;
    bit             m_run = 0, m_done = 0, mon_en = 0;

    function automatic logic [CW-1:0] merge_beat(input int b);
        logic [PW-1:0]  d;
        logic [PSW-1:0] s;
        logic [DW-1:0]  ld;
        logic [SW-1:0]  ls;
        d = '0;
        s = '0;
        for (int ii = 0; ii < N; ii++) begin
            ld = hist_d[ii][b];
            ls = hist_s[ii][b];
            for (int jj = 0; jj < STR; jj++) begin
                d[(jj*N+ii)*EW +: EW] = ld[jj*EW +: EW];
                s[(jj*N+ii)*2 +: 2]   = ls[jj*2 +: 2];
            end
        end
        return {s, d};
    endfunction

    always @(negedge clk_i) begin
        logic          exp_pv, fire, nd;
        logic [N-1:0]  exp_rdy;
        logic [CW-1:0] hd;
        int            mn;
        if (mon_en) begin
            exp_pv = m_run && (exp_q.size() > 0);
            fire   = exp_pv && pop_ready_i;
            for (int ii = 0; ii < N; ii++)
                exp_rdy[ii] = m_run && (m_acc[ii] < m_len) && ((m_acc[ii] == m_beats) || fire);
            chk("busy", CW'(busy_o), CW'(m_run));
            chk("done", CW'(done_o), CW'(m_done));
            chk("beat_cnt", CW'(beat_cnt_o), CW'(m_beats));
            chk("pop_valid", CW'(pop_valid_o), CW'(exp_pv));
            chk("push_ready", CW'(push_ready_o), CW'(exp_rdy));
            if (exp_pv) begin
                hd = exp_q[0];
                chk("pop_data", CW'(pop_data_o), CW'(hd[PW-1:0]));
                chk("pop_strb", CW'(pop_strb_o), CW'(hd[CW-1:PW]));
            end
            if (rst_i || clear_i) begin
                m_run = 0; m_done = 0; m_beats = 0; exp_made = 0;
                exp_q.delete();
                for (int ii = 0; ii < N; ii++) m_acc[ii] = 0;
            end else begin
                nd = 0;
                if (m_run) begin
                    for (int ii = 0; ii < N; ii++) begin
                        if (push_valid_i[ii] && exp_rdy[ii]) begin
                            hist_d[ii][m_acc[ii]] = push_data_i[ii*DW +: DW];
                            hist_s[ii][m_acc[ii]] = push_strb_i[ii*SW +: SW];
                            m_acc[ii]++;
                        end
                    end
                    if (fire) begin
                        void'(exp_q.pop_front());
                        m_beats++;
                        n_fires++;
                        if (m_beats == m_len) begin
                            m_run = 0;
                            nd = 1;
                        end
                    end
                    mn = m_acc[0];
                    for (int ii = 1; ii < N; ii++) if (m_acc[ii] < mn) mn = m_acc[ii];
                    while (exp_made < mn) begin
                        exp_q.push_back(merge_beat(exp_made));
                        exp_made++;
                    end
                end else if (!m_done && start_i) begin
                    if (len_i != 0) begin
                        m_run = 1; m_len = int'(len_i); m_beats = 0; exp_made = 0;
                        exp_q.delete();
                        for (int ii = 0; ii < N; ii++) m_acc[ii] = 0;
                    end else begin
                        nd = 1;
                    end
                end
                m_done = nd;
            end
        end
    end

    // ---------------- lane drivers ----------------
    int             f_left[N], f_delay[N], f_idx[N];
    logic [SW-1:0]  f_strb[N];
    int             tag = 0;
    bit             toggle_rdy = 0;

    function automatic logic [DW-1:0] beat_data(input int ii, input int b);
        logic [DW-1:0] d;
        for (int j = 0; j < STR; j++) d[j*EW +: EW] = {4'(tag), 4'(ii), 4'(b), 4'(j)};
        return d;
    endfunction

    task automatic drive_lanes();
        for (int ii = 0; ii < N; ii++) begin
            if (f_left[ii] > 0 && f_delay[ii] == 0) begin
                push_valid_i[ii]            = 1'b1;
                push_data_i[ii*DW +: DW]    = beat_data(ii, f_idx[ii]);
                push_strb_i[ii*SW +: SW]    = f_strb[ii];
            end else begin
                push_valid_i[ii] = 1'b0;
            end
        end
    endtask

    task automatic setup_lanes(input int t, input int beats);
        tag = t;
        for (int ii = 0; ii < N; ii++) begin
            f_left[ii] = beats; f_delay[ii] = 0; f_idx[ii] = 0; f_strb[ii] = 8'hFF;
        end
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk_i);
        acc = push_valid_i & push_ready_o;
        @(posedge clk_i);
        #1;
        for (int ii = 0; ii < N; ii++) begin
            if (acc[ii]) begin
                f_left[ii]--;
                f_idx[ii]++;
            end else if (f_delay[ii] > 0) begin
                f_delay[ii]--;
            end
        end
        if (toggle_rdy) pop_ready_i = ~pop_ready_i;
        start_i = 1'b0;
        drive_lanes();
    endtask

    task automatic start_xfer(input int len);
        start_i = 1'b1;
        len_i   = LW'(len);
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (done_o !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(name, CW'(done_o), CW'(1));
    endtask

    task automatic wait_pop_valid(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (pop_valid_o !== 1'b1 && cyc < budget) begin
            tick();
            cyc++;
        end
        chk(name, CW'(pop_valid_o), CW'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] held_d;
        int            fires0;
        setup_lanes(0, 0);
        @(posedge clk_i);
        #1;
        mon_en = 1;
        tick();
        rst_i = 1'b0;
        chk("rst_busy", CW'(busy_o), CW'(0));
        chk("rst_pop_valid", CW'(pop_valid_o), CW'(0));
        chk("rst_push_ready", CW'(push_ready_o), CW'(0));
        chk("rst_beat_cnt", CW'(beat_cnt_o), CW'(0));
        tick();

        // Test 1: single beat, interleave pinned by literal elements
        setup_lanes(0, 1);
        drive_lanes();
        start_xfer(1);
        wait_pop_valid("t1_pop_valid", 10);
        chk("t1_elem0", CW'(pop_data_o[0*EW +: EW]), CW'(16'h0000));
        chk("t1_elem6", CW'(pop_data_o[6*EW +: EW]), CW'(16'h0201));
        chk("t1_elem9", CW'(pop_data_o[9*EW +: EW]), CW'(16'h0102));
        chk("t1_elem15", CW'(pop_data_o[15*EW +: EW]), CW'(16'h0303));
        chk("t1_strb", CW'(pop_strb_o), CW'(32'hFFFF_FFFF));
        tick();
        chk("t1_done", CW'(done_o), CW'(1));
        tick();
        chk("t1_idle", CW'(busy_o), CW'(0));

        // Test 2: staggered lanes, output only once the last lane lands
        setup_lanes(1, 0);
        start_xfer(1);
        for (int ii = 0; ii < N; ii++) begin
            f_left[ii] = 1;
        end
        f_delay[0] = 0; f_delay[1] = 1; f_delay[2] = 3; f_delay[3] = 5;
        drive_lanes();
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t2_pop_valid", CW'(pop_valid_o), CW'(k == 6));
            if (k == 2) chk("t2_lane0_ready", CW'(push_ready_o[0]), CW'(0));
        end
        wait_done("t2_done", 10);
        tick();

        // Test 3: eight back-to-back beats, ninth lane beat refused
        setup_lanes(2, 9);
        drive_lanes();
        fires0 = n_fires;
        start_xfer(8);
        wait_done("t3_done", 60);
        chk("t3_fires", CW'(n_fires - fires0), CW'(8));
        chk("t3_beat_cnt", CW'(beat_cnt_o), CW'(8));
        chk("t3_no_ready", CW'(push_ready_o), CW'(0));
        tick();
        chk("t3_busy_low", CW'(busy_o), CW'(0));
        for (int ii = 0; ii < N; ii++) chk("t3_left", CW'(f_left[ii]), CW'(1));
        setup_lanes(2, 0);
        drive_lanes();
        tick();

        // Test 4: stalled output with partial strobes on lane 1
        setup_lanes(3, 4);
        f_strb[1] = 8'h0F;
        drive_lanes();
        toggle_rdy = 1;
        start_xfer(4);
        wait_pop_valid("t4_pop_valid", 10);
        chk("t4_strb", CW'(pop_strb_o), CW'(32'hF3F3_FFFF));
        if (pop_ready_i == 1'b1) tick();
        held_d = pop_data_o;
        chk("t4_stalled", CW'(pop_valid_o && !pop_ready_i), CW'(1));
        tick();
        chk("t4_hold_data", CW'(pop_data_o), CW'(held_d));
        wait_done("t4_done", 40);
        toggle_rdy = 0;
        pop_ready_i = 1'b1;
        tick();

        // Test 5: clear with two lanes buffered, then a clean transfer
        setup_lanes(4, 0);
        f_left[0] = 1; f_left[1] = 1;
        drive_lanes();
        start_xfer(2);
        tick();
        tick();
        chk("t5_full_lanes", CW'(push_ready_o), CW'(4'b1100));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t5_busy", CW'(busy_o), CW'(0));
        chk("t5_pop_valid", CW'(pop_valid_o), CW'(0));
        chk("t5_no_done", CW'(done_o), CW'(0));
        tick();
        chk("t5_no_done2", CW'(done_o), CW'(0));
        setup_lanes(5, 2);
        drive_lanes();
        start_xfer(2);
        wait_pop_valid("t5_pop_valid2", 10);
        chk("t5_fresh", CW'(pop_data_o[5*EW +: EW]), CW'(16'h5101));
        wait_done("t5_done", 20);
        tick();

        // Test 6: zero-length start
        setup_lanes(6, 0);
        drive_lanes();
        start_xfer(0);
        chk("t6_done", CW'(done_o), CW'(1));
        chk("t6_busy", CW'(busy_o), CW'(0));
        chk("t6_ready", CW'(push_ready_o), CW'(0));
        tick();
        chk("t6_done_low", CW'(done_o), CW'(0));
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
